// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// ready-handshaked memory port and traps on illegal encodings or memory timeouts.
module multicycle_controller #(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               br_taken,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_en,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               sel_a,
    output logic               sel_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         wb_sel,
    output logic               rf_en,
    output logic               instr_done,
    output logic               illegal,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB    = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL    = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTU   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR    = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL    = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA    = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_OR     = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND    = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_PASS_B = ALUOP_W'(10);

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_e       state_q, state_d;
    logic         illegal_q, illegal_d;
    logic         tmo_q, tmo_d;
    logic [7:0]   cnt_q, cnt_d;

    class_e             cls;
    logic [ALUOP_W-1:0] funct_op;
    logic               alu_sel_a;
    logic               alu_sel_b;
    logic [ALUOP_W-1:0] alu_op;

    logic               mem_req_c, mem_we_c, ir_en_c, pc_en_c, pc_sel_c;
    logic               sel_a_c, sel_b_c, rf_en_c, done_c;
    logic [ALUOP_W-1:0] aluop_c;
    logic [1:0]         wb_sel_c;

    // Instruction class from the IR; C_BAD covers unknown opcodes and illegal funct fields.
    always_comb begin
        cls = C_BAD;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    cls = C_R;
            end
            OP_IALU: begin
                cls = C_IALU;
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    cls = C_BAD;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    cls = C_BAD;
            end
            OP_LOAD: begin
                if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7)
                    cls = C_LOAD;
            end
            OP_STORE: begin
                if (funct3 <= 3'd2)
                    cls = C_STORE;
            end
            OP_BRANCH: begin
                if (funct3 != 3'd2 && funct3 != 3'd3)
                    cls = C_BRANCH;
            end
            OP_JAL:   cls = C_JAL;
            OP_JALR:  cls = C_JALR;
            OP_LUI:   cls = C_LUI;
            OP_AUIPC: cls = C_AUIPC;
            default:  cls = C_BAD;
        endcase
    end

    // funct7[5] selects SUB only for register-register ops; ADDI ignores it.
    always_comb begin
        case (funct3)
            3'b000:  funct_op = (cls == C_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b011:  funct_op = ALU_SLTU;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_sel_a = 1'b0;
        alu_sel_b = 1'b0;
        alu_op    = ALU_ADD;
        case (cls)
            C_R: alu_op = funct_op;
            C_IALU: begin
                alu_sel_b = 1'b1;
                alu_op    = funct_op;
            end
            C_LUI: begin
                alu_sel_b = 1'b1;
                alu_op    = ALU_PASS_B;
            end
            C_AUIPC, C_JAL, C_BRANCH: begin
                alu_sel_a = 1'b1;
                alu_sel_b = 1'b1;
            end
            C_LOAD, C_STORE, C_JALR: alu_sel_b = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        tmo_d     = tmo_q;
        cnt_d     = '0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls == C_BAD) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls == C_BRANCH)
                    state_d = S_FETCH;
                else if (cls == C_LOAD || cls == C_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: if (mem_ready) state_d = (cls == C_STORE) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
        // Only a wait cycle can time out, so a ready on the limit cycle still completes.
        if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            if (cnt_q == TMO_LIMIT) begin
                state_d = S_TRAP;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_en_c   = 1'b0;
        pc_en_c   = 1'b0;
        pc_sel_c  = 1'b0;
        sel_a_c   = 1'b0;
        sel_b_c   = 1'b0;
        aluop_c   = '0;
        wb_sel_c  = 2'd0;
        rf_en_c   = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                ir_en_c   = mem_ready;
            end
            S_EXEC: begin
                sel_a_c = alu_sel_a;
                sel_b_c = alu_sel_b;
                aluop_c = alu_op;
                if (cls == C_BRANCH) begin
                    pc_en_c  = 1'b1;
                    pc_sel_c = br_taken;
                    done_c   = 1'b1;
                end
            end
            S_MEM: begin
                sel_a_c   = alu_sel_a;
                sel_b_c   = alu_sel_b;
                aluop_c   = alu_op;
                mem_req_c = 1'b1;
                mem_we_c  = (cls == C_STORE);
                if (mem_ready && cls == C_STORE) begin
                    pc_en_c = 1'b1;
                    done_c  = 1'b1;
                end
            end
            S_WB: begin
                sel_a_c  = alu_sel_a;
                sel_b_c  = alu_sel_b;
                aluop_c  = alu_op;
                rf_en_c  = 1'b1;
                pc_en_c  = 1'b1;
                done_c   = 1'b1;
                pc_sel_c = (cls == C_JAL || cls == C_JALR);
                if (cls == C_LOAD)
                    wb_sel_c = 2'd1;
                else if (cls == C_JAL || cls == C_JALR)
                    wb_sel_c = 2'd2;
            end
            default: ;
        endcase
    end

    // Reset state is FETCH, so outputs are forced low while rst is held.
    assign mem_req     = mem_req_c & ~rst;
    assign mem_we      = mem_we_c & ~rst;
    assign ir_en       = ir_en_c & ~rst;
    assign pc_en       = pc_en_c & ~rst;
    assign pc_sel      = pc_sel_c & ~rst;
    assign sel_a       = sel_a_c & ~rst;
    assign sel_b       = sel_b_c & ~rst;
    assign aluop       = rst ? '0 : aluop_c;
    assign wb_sel      = rst ? 2'd0 : wb_sel_c;
    assign rf_en       = rf_en_c & ~rst;
    assign instr_done  = done_c & ~rst;
    assign illegal     = illegal_q & ~rst;
    assign timeout_err = tmo_q & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: an instruction-level
// model expands each instruction into its expected per-cycle control trace.
module tb_multicycle_controller;

    localparam int MT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_en, pc_en, pc_sel, sel_a, sel_b;
    logic [3:0] aluop;
    logic [1:0] wb_sel;
    logic       rf_en, instr_done, illegal, timeout_err;

    multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .sel_a(sel_a), .sel_b(sel_b),
        .aluop(aluop), .wb_sel(wb_sel), .rf_en(rf_en), .instr_done(instr_done),
        .illegal(illegal), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, ir_en, pc_en, pc_sel, sel_a, sel_b;
        logic [3:0] aluop;
        logic [1:0] wb_sel;
        logic       rf_en, done, ill, to;
    } ov_t;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_t;

    ov_t obs;
    assign obs = {mem_req, mem_we, ir_en, pc_en, pc_sel, sel_a, sel_b, aluop, wb_sel,
                  rf_en, instr_done, illegal, timeout_err};

    int  checks = 0;
    int  errors = 0;
    ov_t exp_q[$];
    int  rdy_q[$];   // 0/1 = drive mem_ready, 2 = don't care (random)

    function automatic kind_t kind_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_BAD;
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_BAD;
                return K_I;
            end
            7'h03: return (f3 == 3'd3 || f3 >= 3'd6) ? K_BAD : K_LD;
            7'h23: return (f3 > 3'd2) ? K_BAD : K_ST;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
            7'h6F: return K_JAL;
            7'h67: return K_JALR;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input kind_t k, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && k == K_R && f7 == 7'h20) return 4'd1;
        if (f3 == 3'd5 && f7 == 7'h20) return 4'd7;
        return tab[f3];
    endfunction

    function automatic void push(input ov_t e, input int r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, fw/mw = wait cycles before mem_ready.
    function automatic void build_seq(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      input logic br, input int fw, input int mw);
        kind_t k;
        ov_t   e, alu;
        k = kind_of(op, f3, f7);
        exp_q.delete();
        rdy_q.delete();
        e = '0; e.mem_req = 1'b1;
        if (fw >= MT) begin
            repeat (MT) push(e, 0);
            e = '0; e.to = 1'b1;
            repeat (3) push(e, 2);
            return;
        end
        repeat (fw) push(e, 0);
        e.ir_en = 1'b1; push(e, 1);
        e = '0; push(e, 2);
        if (k == K_BAD) begin
            e.ill = 1'b1;
            repeat (3) push(e, 2);
            return;
        end
        alu = '0;
        case (k)
            K_R: alu.aluop = alu_of(k, f3, f7);
            K_I: begin alu.sel_b = 1'b1; alu.aluop = alu_of(k, f3, f7); end
            K_LUI: begin alu.sel_b = 1'b1; alu.aluop = 4'd10; end
            K_AUIPC, K_JAL, K_BR: begin alu.sel_a = 1'b1; alu.sel_b = 1'b1; end
            default: alu.sel_b = 1'b1;
        endcase
        e = alu;
        if (k == K_BR) begin
            e.pc_en = 1'b1; e.pc_sel = br; e.done = 1'b1;
            push(e, 2);
            return;
        end
        push(e, 2);
        if (k == K_LD || k == K_ST) begin
            e = alu; e.mem_req = 1'b1; e.mem_we = (k == K_ST);
            if (mw >= MT) begin
                repeat (MT) push(e, 0);
                e = '0; e.to = 1'b1;
                repeat (3) push(e, 2);
                return;
            end
            repeat (mw) push(e, 0);
            if (k == K_ST) begin e.pc_en = 1'b1; e.done = 1'b1; end
            push(e, 1);
            if (k == K_ST) return;
        end
        e = alu; e.rf_en = 1'b1; e.pc_en = 1'b1; e.done = 1'b1;
        e.wb_sel = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        e.pc_sel = (k == K_JAL || k == K_JALR);
        push(e, 2);
    endfunction

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic br);
        opcode = op; funct3 = f3; funct7 = f7; br_taken = br;
    endtask

    // Enters with time at posedge+1; leaves with rst released, DUT in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ov_t fe;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ov_t'(0)) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, ov_t'(0)); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        fe = '0; fe.mem_req = 1'b1;
        checks++;
        if (obs !== fe) begin errors++; $display("FAIL reset_fetch obs=%h exp=%h", obs, fe); end
    endtask

    task automatic test_add();
        set_ir(7'h33, 3'd0, 7'h00, 1'b0);
        build_seq(7'h33, 3'd0, 7'h00, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            mem_ready = (rdy_q[i] == 2) ? 1'b1 : (rdy_q[i] == 1);
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL add cyc%0d obs=%h exp=%h", i, obs, exp_q[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shifts();
        logic [16:0] tab [5] = '{{7'h13, 3'd5, 7'h20}, {7'h13, 3'd5, 7'h00}, {7'h13, 3'd1, 7'h00},
                                 {7'h33, 3'd0, 7'h20}, {7'h33, 3'd5, 7'h20}};
        for (int t = 0; t < 5; t++) begin
            set_ir(tab[t][16:10], tab[t][9:7], tab[t][6:0], 1'b0);
            build_seq(tab[t][16:10], tab[t][9:7], tab[t][6:0], 1'b0, t % 2, 0);
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL shift%0d cyc%0d obs=%h exp=%h", t, i, obs, exp_q[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_store();
        logic [6:0] ops [4] = '{7'h03, 7'h23, 7'h03, 7'h23};
        int         mws [4] = '{3, 2, 0, 0};
        for (int t = 0; t < 4; t++) begin
            set_ir(ops[t], 3'd2, 7'h00, 1'b0);
            build_seq(ops[t], 3'd2, 7'h00, 1'b0, 1, mws[t]);
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL ldst%0d cyc%0d obs=%h exp=%h", t, i, obs, exp_q[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [10:0] tab [6] = '{{7'h63, 3'd0, 1'b1}, {7'h63, 3'd0, 1'b0}, {7'h6F, 3'd0, 1'b1},
                                 {7'h67, 3'd0, 1'b0}, {7'h37, 3'd3, 1'b1}, {7'h17, 3'd6, 1'b0}};
        for (int t = 0; t < 6; t++) begin
            set_ir(tab[t][10:4], tab[t][3:1], 7'h00, tab[t][0]);
            build_seq(tab[t][10:4], tab[t][3:1], 7'h00, tab[t][0], 0, 0);
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL brj%0d cyc%0d obs=%h exp=%h", t, i, obs, exp_q[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       br;
        for (int n = 0; n < 40; n++) begin
            op = 7'h33; f3 = 3'd0; f7 = 7'h00;
            for (int tries = 0; tries < 50; tries++) begin
                op = ops[$urandom_range(0, 8)];
                f3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       f7 = 7'h00;
                    1:       f7 = 7'h20;
                    default: f7 = 7'($urandom_range(0, 127));
                endcase
                if (kind_of(op, f3, f7) != K_BAD) break;
                op = 7'h33; f3 = 3'd0; f7 = 7'h00;
            end
            br = ($urandom_range(0, 1) == 1);
            set_ir(op, f3, f7, br);
            build_seq(op, f3, f7, br, $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b%0d op=%h f3=%0d f7=%h cyc%0d obs=%h exp=%h", n, op, f3, f7, i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] tab [8] = '{{7'h7F, 3'd0, 7'h00}, {7'h33, 3'd0, 7'h01}, {7'h33, 3'd1, 7'h20},
                                 {7'h13, 3'd1, 7'h20}, {7'h03, 3'd3, 7'h00}, {7'h23, 3'd3, 7'h00},
                                 {7'h63, 3'd2, 7'h00}, {7'h13, 3'd5, 7'h10}};
        ov_t fe;
        fe = '0; fe.mem_req = 1'b1;
        for (int t = 0; t < 8; t++) begin
            set_ir(tab[t][16:10], tab[t][9:7], tab[t][6:0], 1'b1);
            build_seq(tab[t][16:10], tab[t][9:7], tab[t][6:0], 1'b1, 0, 0);
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL illegal%0d cyc%0d obs=%h exp=%h", t, i, obs, exp_q[i]); end
                @(posedge clk); #1;
            end
            do_reset();
            #1;
            checks++;
            if (obs !== fe) begin errors++; $display("FAIL illegal%0d_clear obs=%h exp=%h", t, obs, fe); end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] ops [4] = '{7'h33, 7'h33, 7'h03, 7'h03};
        int         fws [4] = '{MT, MT - 1, 0, 2};
        int         mws [4] = '{0, 0, MT, MT - 1};
        ov_t fe;
        fe = '0; fe.mem_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            set_ir(ops[t], (ops[t] == 7'h03) ? 3'd2 : 3'd0, 7'h00, 1'b0);
            build_seq(ops[t], (ops[t] == 7'h03) ? 3'd2 : 3'd0, 7'h00, 1'b0, fws[t], mws[t]);
            foreach (exp_q[i]) begin
                mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin errors++; $display("FAIL timeout%0d cyc%0d obs=%h exp=%h", t, i, obs, exp_q[i]); end
                @(posedge clk); #1;
            end
            do_reset();
            #1;
            checks++;
            if (obs !== fe) begin errors++; $display("FAIL timeout%0d_clear obs=%h exp=%h", t, obs, fe); end
        end
    endtask

    task automatic test_reset_mid_mem();
        ov_t fe;
        fe = '0; fe.mem_req = 1'b1;
        set_ir(7'h23, 3'd2, 7'h00, 1'b0);
        build_seq(7'h23, 3'd2, 7'h00, 1'b0, 0, 10);
        for (int i = 0; i < 5; i++) begin
            mem_ready = (rdy_q[i] == 2) ? ($urandom_range(0, 1) == 1) : (rdy_q[i] == 1);
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin errors++; $display("FAIL midmem cyc%0d obs=%h exp=%h", i, obs, exp_q[i]); end
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== ov_t'(0)) begin errors++; $display("FAIL midmem_rst obs=%h exp=%h", obs, ov_t'(0)); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== fe) begin errors++; $display("FAIL midmem_fetch obs=%h exp=%h", obs, fe); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shifts();
        test_load_store();
        test_branch_jump();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
